// File: rtl/lsu_partial_access_pkg.sv
// Shared definitions for the partial-width load/store unit.
//   - FSM state encodings (IDLE/ISSUE/WAIT/RESP)
//   - RISC-V funct3 size/sign codes for loads and stores
//   - lsu_req_err(): size legality plus natural-alignment check
package lsu_partial_access_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Stores share the low codes; bit 2 set on a store is illegal.
    localparam logic [2:0] F3_SB = F3_LB;
    localparam logic [2:0] F3_SH = F3_LH;
    localparam logic [2:0] F3_SW = F3_LW;
    localparam logic [2:0] F3_SD = F3_LD;

    // Returns 1 when the request must be answered with an error and no
    // bus traffic: an illegal size/sign code or a misaligned address.
    function automatic logic lsu_req_err(
        input logic       wen,
        input logic [2:0] func3,
        input logic [2:0] addr_lo,
        input int         data_width
    );
        logic illegal;
        logic misaligned;
        illegal = (wen && func3[2])
               || (func3[2] && func3[1:0] == 2'b11)
               || (data_width == 32 && func3[1:0] == 2'b11)
               || (data_width == 32 && func3 == F3_LWU);
        case (func3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo[1:0];
            default: misaligned = |addr_lo;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_partial_access_if.sv
// Core-side request/response and data-memory bus signals of the LSU.
//   slave  : the LSU's view (drives req_ready, resp_*, mem_req_valid/mem_*)
//   master : the environment's view (core + memory), the opposite directions
interface lsu_partial_access_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [2:0]            req_func3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_func3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output req_valid, req_wen, req_func3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_partial_access_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
//   Store path: st_wdata shifted into lane st_off, plus byte strobes
//               covering (1 << st_size) bytes starting at st_off.
//   Load path : ld_rdata shifted down from lane ld_off, truncated to
//               (1 << ld_size) bytes, sign-extended when ld_sext else
//               zero-extended to DATA_WIDTH.
// Kept free of state so it can be shared with other refill/align paths.
module lsu_lane_align #(
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int OFF_W = $clog2(STRB_WIDTH)
) (
    input  logic [OFF_W-1:0]      st_off,
    input  logic [1:0]            st_size,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [DATA_WIDTH-1:0] st_wdata_sh,
    output logic [STRB_WIDTH-1:0] st_wstrb,

    input  logic [OFF_W-1:0]      ld_off,
    input  logic [1:0]            ld_size,
    input  logic                  ld_sext,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] ld_sh;
    logic                  ld_sign;
    int                    st_nbytes;
    int                    ld_nbits;

    always_comb begin
        st_nbytes   = 1 << st_size;
        st_wdata_sh = st_wdata << {st_off, 3'b000};
        st_wstrb    = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            st_wstrb[i] = (i >= int'(st_off)) && (i < int'(st_off) + st_nbytes);
        end
    end

    always_comb begin
        ld_sh    = ld_rdata >> {ld_off, 3'b000};
        // An 8-byte size can only reach here legally on a 64-bit bus; clamp
        // so a 32-bit build never indexes past the word.
        ld_nbits = 8 << ld_size;
        if (ld_nbits > DATA_WIDTH) ld_nbits = DATA_WIDTH;
        case (ld_size)
            2'd0:    ld_sign = ld_sh[7];
            2'd1:    ld_sign = ld_sh[15];
            2'd2:    ld_sign = ld_sh[31];
            default: ld_sign = ld_sh[DATA_WIDTH-1];
        endcase
        ld_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ld_data[i] = (i < ld_nbits) ? ld_sh[i] : (ld_sext & ld_sign);
        end
    end

endmodule

// File: rtl/lsu_partial_access.sv
// lsu_partial_access: one-outstanding-transaction partial-width LSU.
// Turns sized RISC-V loads/stores (B/H/W, D on a 64-bit bus) into one
// aligned bus beat with byte strobes, then extends the returned load data.
// Illegal sizes and misaligned addresses are answered with resp_err=1
// without touching the bus.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsu_partial_access_if.slave
//              req_*  core request (valid/ready)
//              resp_* result to core (valid/ready), rdata 0 for stores/errors
//              mem_*  data-memory bus request, write ack / read data
// All outputs are registered except req_ready, which is decoded from state.
// DATA_WIDTH must be 32 or 64.
module lsu_partial_access
    import lsu_partial_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input logic                 clk,
    input logic                 rst,
    lsu_partial_access_if.slave bus
);

    localparam int OFF_W = $clog2(STRB_WIDTH);

    logic [1:0]            state_q, state_d;
    logic [2:0]            func3_q, func3_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic                  req_err;
    logic [DATA_WIDTH-1:0] st_wdata_sh;
    logic [STRB_WIDTH-1:0] st_wstrb;
    logic [DATA_WIDTH-1:0] ld_data;

    assign req_err = lsu_req_err(bus.req_wen, bus.req_func3, bus.req_addr[2:0], DATA_WIDTH);

    // Store lanes come straight from the incoming request so the beat can
    // be registered at accept; load lanes use the latched offset/size.
    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_off      (bus.req_addr[OFF_W-1:0]),
        .st_size     (bus.req_func3[1:0]),
        .st_wdata    (bus.req_wdata),
        .st_wdata_sh (st_wdata_sh),
        .st_wstrb    (st_wstrb),
        .ld_off      (off_q),
        .ld_size     (func3_q[1:0]),
        .ld_sext     (~func3_q[2]),
        .ld_rdata    (bus.mem_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        func3_d         = func3_q;
        off_d           = off_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_wen_d       = mem_wen_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wstrb_d     = mem_wstrb_q;
        resp_valid_d    = resp_valid_q;
        resp_err_d      = resp_err_q;
        resp_rdata_d    = resp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    func3_d = bus.req_func3;
                    off_d   = bus.req_addr[OFF_W-1:0];
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d         = ST_ISSUE;
                        mem_req_valid_d = 1'b1;
                        mem_wen_d       = bus.req_wen;
                        mem_addr_d      = {bus.req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wdata_d     = bus.req_wen ? st_wdata_sh : '0;
                        mem_wstrb_d     = bus.req_wen ? st_wstrb : '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d         = ST_WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // Only a response seen here counts; one coincident with the
                // ISSUE handshake was sampled in ISSUE and dropped.
                if (bus.mem_rsp_valid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_wen_q ? '0 : ld_data;
                end
            end
            default: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            func3_q         <= '0;
            off_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            func3_q         <= func3_d;
            off_q           <= off_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_wen_q       <= mem_wen_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_rdata_q    <= resp_rdata_d;
        end
    end

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wstrb     = mem_wstrb_q;

endmodule
